// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RV32I pipeline control blocks.
// Also holds the forwarding-priority helper used by forward_unit.
package rv_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int WAIT_W = 8;

    // The MEM result is younger than the WB result, so it wins when both match.
    function automatic logic [1:0] fwdSel(
        input logic [4:0] rs,
        input logic [4:0] rdM,
        input logic       regWriteM,
        input logic [4:0] rdW,
        input logic       regWriteW
    );
        if (regWriteM && (rdM != REG_X0) && (rdM == rs)) begin
            return FWD_MEM;
        end else if (regWriteW && (rdW != REG_X0) && (rdW == rs)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding select for both ALU sources.
// Purely combinational.
module forward_unit
    import rv_pipe_pkg::*;
(
    input  logic [4:0] rs1E_i,
    input  logic [4:0] rs2E_i,
    input  logic [4:0] rdM_i,
    input  logic [4:0] rdW_i,
    input  logic       regWriteM_i,
    input  logic       regWriteW_i,
    output logic [1:0] fwdA_o,
    output logic [1:0] fwdB_o
);

    assign fwdA_o = fwdSel(rs1E_i, rdM_i, regWriteM_i, rdW_i, regWriteW_i);
    assign fwdB_o = fwdSel(rs2E_i, rdM_i, regWriteM_i, rdW_i, regWriteW_i);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and redirect handling, a memory-wait
// freeze FSM with timeout trap, and a saturating stall-cycle counter.
module hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             MemReadE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic [CNT_W-1:0]  stallCnt_q;

    logic       loadUse;
    logic       stallF_d, stallD_d, stallE_d, stallM_d;
    logic       flushD_d, flushE_d, flushW_d;
    logic [1:0] fwdA, fwdB;

    forward_unit uForward (
        .rs1E_i      (Rs1E),
        .rs2E_i      (Rs2E),
        .rdM_i       (RdM),
        .rdW_i       (RdW),
        .regWriteM_i (RegWriteM),
        .regWriteW_i (RegWriteW),
        .fwdA_o      (fwdA),
        .fwdB_o      (fwdB)
    );

    assign loadUse = MemReadE && (RdE != REG_X0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        stallF_d  = 1'b0;
        stallD_d  = 1'b0;
        stallE_d  = 1'b0;
        stallM_d  = 1'b0;
        flushD_d  = 1'b0;
        flushE_d  = 1'b0;
        flushW_d  = 1'b0;

        unique case (state_q)
            RUN, MEM_WAIT: begin
                if (MemReqM && !MemReadyM) begin
                    // Freeze everything up to MEM and bubble WB; redirects wait until ready.
                    {stallF_d, stallD_d, stallE_d, stallM_d, flushW_d} = '1;
                    if (state_q == RUN) begin
                        state_d   = MEM_WAIT;
                        waitCnt_d = WAIT_W'(1);
                    end else if (waitCnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d = MEM_ERR;
                    end else begin
                        waitCnt_d = waitCnt_q + WAIT_W'(1);
                    end
                end else if (state_q == MEM_WAIT && !MemReadyM) begin
                    // Request dropped while waiting: stay frozen until the memory answers.
                    {stallF_d, stallD_d, stallE_d, stallM_d, flushW_d} = '1;
                    if (waitCnt_q == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d = MEM_ERR;
                    end else begin
                        waitCnt_d = waitCnt_q + WAIT_W'(1);
                    end
                end else begin
                    state_d   = RUN;
                    waitCnt_d = '0;
                    if (PCSrcE) begin
                        flushD_d = 1'b1;
                        flushE_d = 1'b1;
                    end else if (loadUse) begin
                        stallF_d = 1'b1;
                        stallD_d = 1'b1;
                        flushE_d = 1'b1;
                    end
                end
            end
            MEM_ERR: begin
                {stallF_d, stallD_d, stallE_d, stallM_d, flushW_d} = '1;
            end
            default: begin
                state_d   = RUN;
                waitCnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            waitCnt_q  <= '0;
            stallCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            if (stallF_d && (stallCnt_q != '1)) begin
                stallCnt_q <= stallCnt_q + CNT_W'(1);
            end
        end
    end

    // While reset is held the pipeline controls are forced quiet regardless of inputs.
    assign StallF       = reset & stallF_d;
    assign StallD       = reset & stallD_d;
    assign StallE       = reset & stallE_d;
    assign StallM       = reset & stallM_d;
    assign FlushD       = reset & flushD_d;
    assign FlushE       = reset & flushE_d;
    assign FlushW       = reset & flushW_d;
    assign ForwardAE    = reset ? fwdA : FWD_RF;
    assign ForwardBE    = reset ? fwdB : FWD_RF;
    assign mem_err      = (state_q == MEM_ERR);
    assign stall_cycles = stallCnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl, with hand sequences for the
// memory-wait, timeout, counter saturation and asynchronous reset cases.
module tb_hazard_ctrl;
    import rv_pipe_pkg::*;

    typedef struct {
        string      name;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       memReadE, regWriteM, regWriteW, pcSrcE, memReqM, memReadyM;
        logic [10:0] expOut;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        MemReadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        mem_err;
    logic [31:0] stall_cycles;

    logic        sStallF, sStallD, sStallE, sStallM, sFlushD, sFlushE, sFlushW;
    logic [1:0]  sFwdA, sFwdB;
    logic        sMemErr;
    logic [2:0]  sStallCycles;

    int nChecks = 0;
    int nFails  = 0;

    vec_t vecs[12];

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .MemReadE(MemReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    // Narrow-counter copy driven by the same stimulus, to exercise saturation.
    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dutSmall (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .MemReadE(MemReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(sStallF), .StallD(sStallD), .StallE(sStallE), .StallM(sStallM),
        .FlushD(sFlushD), .FlushE(sFlushE), .FlushW(sFlushW),
        .ForwardAE(sFwdA), .ForwardBE(sFwdB),
        .mem_err(sMemErr), .stall_cycles(sStallCycles)
    );

    task automatic clearInputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        MemReadE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        Rs1D = v.rs1D; Rs2D = v.rs2D; Rs1E = v.rs1E; Rs2E = v.rs2E;
        RdE = v.rdE; RdM = v.rdM; RdW = v.rdW;
        MemReadE = v.memReadE; RegWriteM = v.regWriteM; RegWriteW = v.regWriteW;
        PCSrcE = v.pcSrcE; MemReqM = v.memReqM; MemReadyM = v.memReadyM;
    endtask

    // Output word: {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE}
    task automatic checkOutput(input string name, input logic [10:0] expOut);
        logic [10:0] act;
        act = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};
        nChecks++;
        if (act !== expOut) begin
            nFails++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, expOut);
        end
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expVal);
        nChecks++;
        if (act !== expVal) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expVal);
        end
    endtask

    localparam logic [10:0] OUT_IDLE  = 11'b0000000_00_00;
    localparam logic [10:0] OUT_LU    = 11'b1100010_00_00;
    localparam logic [10:0] OUT_REDIR = 11'b0000110_00_00;
    localparam logic [10:0] OUT_FRZ   = 11'b1111001_00_00;

    initial begin
        //          name        rs1D  rs2D  rs1E  rs2E  rdE   rdM   rdW  mrE wM wW pc req rdy  expected
        vecs[0]  = '{"fwdMem",  5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 0, 1, 1, 0, 0, 0, 11'b0000000_10_00};
        vecs[1]  = '{"fwdWb",   5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 0, 0, 1, 0, 0, 0, 11'b0000000_01_00};
        vecs[2]  = '{"fwdX0",   5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, 0, 0, 11'b0000000_00_00};
        vecs[3]  = '{"fwdSplit",5'd0, 5'd0, 5'd3, 5'd4, 5'd0, 5'd4, 5'd3, 0, 1, 1, 0, 0, 0, 11'b0000000_01_10};
        vecs[4]  = '{"fwdBoth", 5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd9, 5'd2, 0, 1, 1, 0, 0, 0, 11'b0000000_10_10};
        vecs[5]  = '{"luRs2",   5'd1, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0, OUT_LU};
        vecs[6]  = '{"luRdX0",  5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 0, OUT_IDLE};
        vecs[7]  = '{"luNoLoad",5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, OUT_IDLE};
        vecs[8]  = '{"brOverLu",5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1, 0, 0, 1, 0, 0, OUT_REDIR};
        vecs[9]  = '{"brOnly",  5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, OUT_REDIR};
        vecs[10] = '{"memHitLu",5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1, 0, 0, 0, 1, 1, OUT_LU};
        vecs[11] = '{"readyNoReq",5'd0,5'd0,5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, OUT_IDLE};

        // Reset with hazard-looking inputs: everything must stay quiet.
        reset = 1'b0;
        clearInputs();
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1; MemReqM = 1; MemReadE = 1; RdE = 5'd7; Rs1D = 5'd7;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("resetOut", OUT_IDLE);
        checkVal("resetCnt", stall_cycles, 0);
        checkVal("resetErr", 32'(mem_err), 0);
        @(negedge clk);
        reset = 1'b1;
        clearInputs();

        // Single load-use bubble, then a clean cycle.
        @(negedge clk);
        MemReadE = 1; RdE = 5'd7; Rs2D = 5'd7;
        #1 checkOutput("luStall", OUT_LU);
        @(negedge clk);
        clearInputs();
        #1 checkOutput("luDone", OUT_IDLE);
        checkVal("luCnt", stall_cycles, 1);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1 checkOutput(vecs[i].name, vecs[i].expOut);
        end
        @(negedge clk);
        clearInputs();
        #1 checkVal("tableCnt", stall_cycles, 3);

        // Three miss cycles with a redirect and load-use held, then ready.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clearInputs();
            MemReqM = 1; MemReadyM = (i == 3);
            PCSrcE = 1; MemReadE = 1; RdE = 5'd7; Rs1D = 5'd7;
            Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1;
            #1 checkOutput($sformatf("memWait%0d", i),
                           (i == 3) ? 11'b0000110_10_00 : 11'b1111001_10_00);
        end
        @(negedge clk);
        clearInputs();
        #1 checkOutput("afterWait", OUT_IDLE);
        checkVal("afterWaitState", 32'(dut.state_q), 32'(RUN));
        checkVal("waitCnt", stall_cycles, 6);

        // Timeout: one RUN miss plus four waiting cycles, then trapped.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clearInputs();
            MemReqM = (i < 8);
            MemReadyM = (i >= 7);
            #1 checkOutput($sformatf("timeout%0d", i), OUT_FRZ);
            checkVal($sformatf("memErr%0d", i), 32'(mem_err), (i >= 5) ? 1 : 0);
        end
        @(negedge clk);
        #1 checkVal("errCnt", stall_cycles, 16);
        checkVal("satCnt", 32'(sStallCycles), 7);
        checkVal("errHeld", 32'(mem_err), 1);

        // Asynchronous reset mid-cycle out of the error trap.
        #2 reset = 1'b0;
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1;
        #1 checkOutput("rstFromErr", OUT_IDLE);
        checkVal("rstErrFlag", 32'(mem_err), 0);
        checkVal("rstCnt", stall_cycles, 0);
        checkVal("rstState", 32'(dut.state_q), 32'(RUN));
        @(negedge clk);
        reset = 1'b1;
        clearInputs();

        // Reset while in MEM_WAIT.
        @(negedge clk);
        MemReqM = 1; MemReadyM = 0;
        #1 checkOutput("mwFirst", OUT_FRZ);
        @(negedge clk);
        #1 checkOutput("mwSecond", OUT_FRZ);
        checkVal("mwState", 32'(dut.state_q), 32'(MEM_WAIT));
        @(posedge clk);
        #2 reset = 1'b0;
        #1 checkOutput("mwReset", OUT_IDLE);
        checkVal("mwWaitCnt", 32'(dut.waitCnt_q), 0);
        checkVal("mwRstState", 32'(dut.state_q), 32'(RUN));
        @(negedge clk);
        reset = 1'b1;
        clearInputs();
        @(negedge clk);
        MemReadE = 1; RdE = 5'd3; Rs1D = 5'd3;
        #1 checkOutput("postRstLu", OUT_LU);
        @(negedge clk);
        clearInputs();
        #1 checkOutput("postRstIdle", OUT_IDLE);
        checkVal("postRstCnt", stall_cycles, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage RV32I core.
- Drives stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the EX-stage forwarding selects.
- Contains a memory-wait FSM that freezes the pipeline while a multi-cycle data-memory access completes, with a timeout error trap.
- Maintains a saturating stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 16, max MEM_WAIT cycles before entering MEM_ERR (legal range 1..255).
- CNT_W, 32, width of stall_cycles counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Rs1D, Rs2D  in  5  source registers in ID
- Rs1E, Rs2E, RdE  in  5  register fields in EX
- RdM, RdW  in  5  destination registers in MEM/WB
- MemReadE  in  1  load in EX
- RegWriteM, RegWriteW  in  1  writeback enables in MEM/WB
- PCSrcE  in  1  taken branch or jump resolved in EX
- MemReqM  in  1  load/store access active in MEM
- MemReadyM  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1  hold PC, IF/ID, ID/EX, EX/MEM
- FlushD, FlushE, FlushW  out  1  bubble into IF/ID, ID/EX, MEM/WB
- ForwardAE, ForwardBE  out  2  00 regfile, 01 from WB, 10 from MEM
- mem_err  out  1  sticky memory-timeout flag
- stall_cycles  out  CNT_W  count of cycles with StallF=1

Behaviour:
- Reset (reset=0, async): state=RUN, wait_cnt=0, mem_err=0, stall_cycles=0. All stall/flush outputs are 0 and forwarding is 00 while in reset.
- Forwarding (combinational, all states):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise ForwardAE=00.
  - ForwardBE uses the same rules with Rs2E. MEM takes priority over WB.
- Load-use (RUN only): lu = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D). When lu=1: StallF=StallD=1 and FlushE=1, giving one bubble. Duration is one cycle, since the load moves to MEM.
- Redirect (RUN only): PCSrcE=1 gives FlushD=FlushE=1 and overrides lu. StallF and StallD are then 0, so the redirected fetch proceeds.
- FSM states: RUN, MEM_WAIT, MEM_ERR. Stall decisions are Mealy, with zero-cycle latency.
- RUN, MemReqM && !MemReadyM:
  - StallF=StallD=StallE=StallM=1 and FlushW=1 this cycle.
  - FlushD/FlushE suppressed; PCSrcE and lu are ignored.
  - Next state MEM_WAIT, wait_cnt<=1.
- RUN, MemReqM && MemReadyM: single-cycle access, no stall, normal hazard rules apply.
- MEM_WAIT, !MemReadyM:
  - All four stalls and FlushW asserted.
  - wait_cnt increments.
  - When wait_cnt==MEM_TIMEOUT on a non-ready cycle, next state is MEM_ERR.
- MEM_WAIT, MemReadyM=1:
  - Stalls drop in the same cycle and the pipeline advances.
  - The held PCSrcE/lu are now evaluated with RUN rules in this cycle.
  - Next state RUN, wait_cnt<=0.
- MEM_ERR:
  - All stalls and FlushW held at 1 and mem_err=1.
  - Exits only on reset; MemReadyM is ignored.
- stall_cycles: increments on every clock with StallF=1 and saturates at all-ones.
- Reset mid-wait: returns to RUN immediately. Any in-flight access is abandoned; the memory side is reset by the same signal.
- Relation to ID/EX register: that register gives flush priority over stall. This block never asserts FlushE together with StallE.

Decomposition:
- Shared package rv_pipe_pkg:
  - hz_state_t enum {RUN, MEM_WAIT, MEM_ERR}
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - REG_X0=5'd0
- Sub-module forward_unit: purely combinational, computes ForwardAE/BE. Instantiated once; the FSM, load-use and redirect logic and the counter stay in hazard_ctrl.

Test Plan:
- Forwarding: RdM=RdW=5, RegWriteM=RegWriteW=1, Rs1E=5 -> ForwardAE=10. Set RegWriteM=0 -> ForwardAE=01. Set RdM=RdW=0 -> ForwardAE=00.
- Load-use: MemReadE=1, RdE=7, Rs2D=7 -> one cycle of StallF=StallD=FlushE=1; next cycle (MemReadE=0) all 0; stall_cycles=1.
- Branch vs load-use: lu conditions plus PCSrcE=1 -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 -> all stalls and FlushW high 3 cycles, low on ready cycle; state RUN after; stall_cycles += 3.
- Timeout: MEM_TIMEOUT=4, MemReadyM held 0 -> MEM_ERR entered after 4 wait cycles, mem_err=1 and stalls held; a later MemReadyM=1 changes nothing; reset low -> all outputs 0, state RUN.
- Reset mid-wait: reset asserted during MEM_WAIT -> outputs 0 asynchronously, wait_cnt=0; after release, normal RUN behaviour.
